// File: rtl/pwm_pkg.sv
// pwm_pkg: shared state type, default widths and saturating ramp arithmetic for the PWM sequencer
package pwm_pkg;
  localparam int DEF_WIDTH = 16;
  localparam int DEF_STEP_W = 8;
  localparam int MAX_W = 32;
  typedef enum logic [1:0] {IDLE, RUN, RAMP, STOP} state_t;
  function automatic logic [MAX_W-1:0] ramp_step(
    input logic [MAX_W-1:0] d,
    input logic [MAX_W-1:0] t,
    input logic [MAX_W-1:0] s
  );
    logic [MAX_W:0] up;
    logic [MAX_W:0] dn;
    up = {1'b0, d} + {1'b0, s};
    dn = {1'b0, d} - {1'b0, s};
    return (s == '0 || d == t) ? t
         : (d < t) ? ((up > {1'b0, t}) ? t : up[MAX_W-1:0])
         : ((dn[MAX_W] || dn[MAX_W-1:0] < t) ? t : dn[MAX_W-1:0]);
  endfunction
endpackage

// File: rtl/pwm_period_counter.sv
// pwm_period_counter: period counter with period latch and wrap detect
module pwm_period_counter import pwm_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] cnt,
  output logic             wrap
);
  logic [WIDTH-1:0] period_q;
  assign wrap = run && cnt == period_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      period_q <= '0;
    end else if (!run || wrap) begin
      cnt <= '0;
      period_q <= period;
    end else begin
      cnt <= cnt + WIDTH'(1);
    end
  end
endmodule

// File: rtl/pwm_ramp_ctrl.sv
// pwm_ramp_ctrl: period-aligned duty sequencer with slew-limited ramps and graceful stop
module pwm_ramp_ctrl import pwm_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int STEP_W = DEF_STEP_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [WIDTH-1:0]  period,
  input  logic [WIDTH-1:0]  tgt_duty,
  input  logic [STEP_W-1:0] tgt_step,
  input  logic              tgt_valid,
  output logic              tgt_ready,
  output logic [WIDTH-1:0]  counter_value,
  output logic [WIDTH-1:0]  duty,
  output logic              pwm_en,
  output logic              period_end,
  output logic              ramp_done,
  output logic              busy
);
  state_t state, nxt;
  logic [WIDTH-1:0] cnt, duty_q, tgt_q, nxt_duty;
  logic [STEP_W-1:0] step_q;
  logic run, wrap, hs, reach, rd_q;
  assign run = state != IDLE;
  assign tgt_ready = !rst && state != STOP;
  assign hs = tgt_valid && tgt_ready;
  assign nxt_duty = WIDTH'(ramp_step(MAX_W'(duty_q), MAX_W'(tgt_q), MAX_W'(step_q)));
  assign reach = state == RAMP && wrap && nxt_duty == tgt_q;
  pwm_period_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk(clk),
    .rst(rst),
    .run(run),
    .period(period),
    .cnt(cnt),
    .wrap(wrap)
  );
  always_comb begin
    nxt = state;
    case (state)
      IDLE:      nxt = !en ? IDLE : (tgt_q != '0) ? RAMP : RUN;
      RUN, RAMP: nxt = !en ? STOP : (hs && tgt_step != '0) ? RAMP : reach ? RUN : state;
      STOP:      nxt = wrap ? IDLE : STOP;
      default:   nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      duty_q <= '0;
      tgt_q <= '0;
      step_q <= '0;
      rd_q <= 1'b0;
      counter_value <= '0;
      duty <= '0;
      pwm_en <= 1'b0;
      period_end <= 1'b0;
      ramp_done <= 1'b0;
      busy <= 1'b0;
    end else begin
      state <= nxt;
      if (hs) begin
        tgt_q <= tgt_duty;
        step_q <= tgt_step;
      end
      duty_q <= (nxt == IDLE) ? '0 : (wrap && state != STOP) ? nxt_duty : duty_q;
      rd_q <= reach;
      counter_value <= cnt;
      duty <= duty_q;
      pwm_en <= run;
      busy <= run;
      period_end <= wrap;
      ramp_done <= rd_q;
    end
  end
endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// tb_pwm_ramp_ctrl: scenario tasks plus a randomized per-period reference model for pwm_ramp_ctrl
module tb_pwm_ramp_ctrl;
  localparam int W = 16;
  localparam int SW = 8;
  logic clk = 1'b0;
  logic rst, en, tgt_valid, tgt_ready, pwm_en, period_end, ramp_done, busy;
  logic [W-1:0] period, tgt_duty, counter_value, duty;
  logic [SW-1:0] tgt_step;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  pwm_ramp_ctrl #(.WIDTH(W), .STEP_W(SW)) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .period(period),
    .tgt_duty(tgt_duty),
    .tgt_step(tgt_step),
    .tgt_valid(tgt_valid),
    .tgt_ready(tgt_ready),
    .counter_value(counter_value),
    .duty(duty),
    .pwm_en(pwm_en),
    .period_end(period_end),
    .ramp_done(ramp_done),
    .busy(busy)
  );

  function automatic int ref_step(input int d, input int t, input int s);
    if (s == 0) return t;
    if (d < t) return (d + s > t) ? t : d + s;
    if (d > t) return (d - s < t) ? t : d - s;
    return d;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; tgt_valid = 1'b0; tgt_duty = '0; tgt_step = '0; period = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic offer(input int d, input int s);
    tgt_duty = W'(d); tgt_step = SW'(s); tgt_valid = 1'b1;
    tick();
    tgt_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; tgt_valid = 1'b1; tgt_duty = 16'd40; tgt_step = '0;
    repeat (3) tick();
    total++;
    if ({counter_value, duty, pwm_en, period_end, ramp_done, busy, tgt_ready} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got=%h exp=0", {counter_value, duty, pwm_en, period_end, ramp_done, busy, tgt_ready});
    end
    rst = 1'b0; tgt_valid = 1'b0;
    #1;
    total++;
    if (tgt_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_ready got=%b exp=1", tgt_ready);
    end
    tick();
    total++;
    if ({counter_value, duty, pwm_en, period_end, ramp_done, busy} !== '0) begin
      bad++;
      $display("FAIL idle_outputs got=%h exp=0", {counter_value, duty, pwm_en, period_end, ramp_done, busy});
    end
  endtask

  task automatic test_jump();
    logic [2*W+2:0] got, exp;
    int cv;
    do_reset();
    period = 16'd9; en = 1'b1;
    tick();
    for (int k = 1; k <= 25; k++) begin
      tgt_valid = (k == 4); tgt_duty = 16'd4; tgt_step = '0;
      tick();
      cv = (k - 1) % 10;
      got = {pwm_en, period_end, ramp_done, counter_value, duty};
      exp = {1'b1, cv == 9, 1'b0, W'(cv), (k >= 11) ? 16'd4 : 16'd0};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL jump k=%0d got=%h exp=%h", k, got, exp);
      end
    end
    tgt_valid = 1'b0;
  endtask

  task automatic test_ramp();
    logic [2*W+2:0] got, exp;
    int tbl [7] = '{0, 20, 40, 50, 30, 10, 5};
    int cv;
    do_reset();
    period = 16'd99;
    offer(50, 20);
    en = 1'b1;
    tick();
    for (int k = 1; k <= 700; k++) begin
      tgt_valid = (k == 310); tgt_duty = 16'd5; tgt_step = 8'd20;
      tick();
      cv = (k - 1) % 100;
      got = {pwm_en, period_end, ramp_done, counter_value, duty};
      exp = {1'b1, cv == 99, k == 301 || k == 601, W'(cv), W'(tbl[(k - 1) / 100])};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL ramp k=%0d got=%h exp=%h", k, got, exp);
      end
    end
    tgt_valid = 1'b0;
  endtask

  task automatic test_retarget();
    logic [2*W+2:0] got, exp;
    int tbl [7] = '{0, 10, 20, 30, 15, 0, 0};
    int cv;
    do_reset();
    period = 16'd4;
    offer(80, 10);
    en = 1'b1;
    tick();
    for (int k = 1; k <= 35; k++) begin
      tgt_valid = (k == 17); tgt_duty = 16'd0; tgt_step = 8'd15;
      tick();
      cv = (k - 1) % 5;
      got = {pwm_en, period_end, ramp_done, counter_value, duty};
      exp = {1'b1, cv == 4, k == 26, W'(cv), W'(tbl[(k - 1) / 5])};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL retarget k=%0d got=%h exp=%h", k, got, exp);
      end
    end
    tgt_valid = 1'b0;
  endtask

  task automatic test_stop();
    logic [2*W+3:0] got, exp;
    do_reset();
    period = 16'd9; en = 1'b1;
    tick();
    for (int k = 1; k <= 14; k++) begin
      en = (k < 4) || (k == 6);
      tick();
      got = {pwm_en, busy, period_end, tgt_ready, counter_value, duty};
      exp = {k <= 10, k <= 10, k == 10, k < 4 || k >= 10, W'((k <= 10) ? k - 1 : 0), 16'd0};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL stop k=%0d got=%h exp=%h", k, got, exp);
      end
    end
  endtask

  task automatic test_period0();
    logic [2*W+2:0] got, exp;
    do_reset();
    period = 16'd0; en = 1'b1;
    tick();
    for (int k = 1; k <= 8; k++) begin
      tgt_valid = (k == 3); tgt_duty = 16'd7; tgt_step = '0;
      tick();
      got = {pwm_en, period_end, ramp_done, counter_value, duty};
      exp = {1'b1, 1'b1, 1'b0, 16'd0, (k >= 5) ? 16'd7 : 16'd0};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL period0 k=%0d got=%h exp=%h", k, got, exp);
      end
    end
    tgt_valid = 1'b0;
  endtask

  task automatic test_saturation();
    logic [2*W+2:0] got, exp;
    int cv;
    do_reset();
    period = 16'd100;
    offer(65535, 0);
    en = 1'b1;
    tick();
    for (int k = 1; k <= 210; k++) begin
      tick();
      cv = (k - 1) % 101;
      got = {pwm_en, period_end, ramp_done, counter_value, duty};
      exp = {1'b1, cv == 100, k == 102, W'(cv), (k >= 102) ? 16'hFFFF : 16'h0000};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL saturation k=%0d got=%h exp=%h", k, got, exp);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    period = 16'd9;
    offer(80, 10);
    en = 1'b1;
    tick();
    repeat (25) tick();
    total++;
    if (duty !== 16'd20) begin
      bad++;
      $display("FAIL midramp_duty got=%0d exp=20", duty);
    end
    rst = 1'b1; tgt_valid = 1'b1; tgt_duty = 16'd40; tgt_step = '0;
    tick();
    total++;
    if ({counter_value, duty, pwm_en, period_end, ramp_done, busy, tgt_ready} !== '0) begin
      bad++;
      $display("FAIL rst_midramp got=%h exp=0", {counter_value, duty, pwm_en, period_end, ramp_done, busy, tgt_ready});
    end
    rst = 1'b0; tgt_valid = 1'b0;
    tick();
    for (int k = 1; k <= 12; k++) begin
      tick();
      total++;
      if ({pwm_en, counter_value, duty} !== {1'b1, W'((k - 1) % 10), 16'd0}) begin
        bad++;
        $display("FAIL rst_drop_hs k=%0d got=%h exp=%h", k, {pwm_en, counter_value, duty}, {1'b1, W'((k - 1) % 10), 16'd0});
      end
    end
  endtask

  task automatic test_random();
    logic [2*W+2:0] got, exp;
    logic v;
    int p, cv, d_int, rd_int, t, s, ramping, nd, ns, ed, erd;
    for (int trial = 0; trial < 6; trial++) begin
      p = int'($urandom_range(0, 9));
      do_reset();
      period = W'(p); en = 1'b1;
      tick();
      d_int = 0; rd_int = 0; t = 0; s = 0; ramping = 0;
      for (int k = 1; k <= 8 * (p + 1) + 4; k++) begin
        v = ($urandom_range(0, 3) == 0);
        nd = int'($urandom_range(0, 300));
        ns = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 40));
        tgt_valid = v; tgt_duty = W'(nd); tgt_step = SW'(ns);
        ed = d_int; erd = rd_int;
        tick();
        rd_int = 0;
        if (k % (p + 1) == 0) begin
          d_int = ref_step(d_int, t, s);
          if (ramping != 0 && d_int == t) begin
            rd_int = 1;
            ramping = 0;
          end
        end
        if (v) begin
          t = nd;
          s = ns;
          if (ns != 0) ramping = 1;
        end
        cv = (k - 1) % (p + 1);
        got = {pwm_en, period_end, ramp_done, counter_value, duty};
        exp = {1'b1, cv == p, erd != 0, W'(cv), W'(ed)};
        total++;
        if (got !== exp) begin
          bad++;
          $display("FAIL random trial=%0d p=%0d k=%0d got=%h exp=%h", trial, p, k, got, exp);
        end
      end
      tgt_valid = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; tgt_valid = 1'b0; tgt_duty = '0; tgt_step = '0; period = '0;
    test_reset();
    test_jump();
    test_ramp();
    test_retarget();
    test_stop();
    test_period0();
    test_saturation();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pwm_ramp_ctrl.md
# pwm_ramp_ctrl

Sequencer for the PWM comparator datapath. It owns the period counter and the duty value that the comparator reads. New duty targets arrive over a valid/ready handshake and are applied only at period boundaries, so no output pulse is ever truncated. Targets can be reached gradually with a per-period slew step for soft-start and soft-stop, and a disable finishes the current period before stopping.

## Interface
- `WIDTH`, 16: width of counter, period and duty; must match the comparator.
- `STEP_W`, 8: width of the ramp step.
- `clk`  in  1: single clock; all logic is on the rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `en`  in  1: run request; level-sensitive.
- `period`  in  WIDTH: terminal count. The counter runs 0..period inclusive, so one PWM cycle is period+1 clocks. The value is sampled at wrap and on IDLE→RUN.
- `tgt_duty`  in  WIDTH: requested duty.
- `tgt_step`  in  STEP_W: ramp step per period; 0 means jump.
- `tgt_valid`  in  1: target offer.
- `tgt_ready`  out  1: target accepted on a cycle where `tgt_valid && tgt_ready`.
- `counter_value`  out  WIDTH: counter to the comparator.
- `duty`  out  WIDTH: applied duty to the comparator.
- `pwm_en`  out  1: comparator enable.
- `period_end`  out  1: one-clock pulse on the cycle where counter_value == period_q.
- `ramp_done`  out  1: one-clock pulse when the applied duty first equals the target.
- `busy`  out  1: high when the state is not IDLE.

## Operation
- **Registers:**
  - `period_q`: latched period.
  - `cnt`: the counter.
  - `duty_q`: applied duty.
  - `tgt_q`: target duty.
  - `step_q`: ramp step.
  - `state`.
- **States:**
  - IDLE: cnt=0, duty_q=0, pwm_en=0.
  - RUN: steady duty.
  - RAMP: duty moving toward tgt_q.
  - STOP: finishing the last period.
- **Transitions:**
  - IDLE→RUN when en=1. If tgt_q≠0, go to RAMP instead; duty_q starts at 0.
  - RUN→RAMP on handshake. If tgt_step==0, the new value is instead copied to duty_q at the next wrap, and the state stays RUN.
  - RAMP→RUN when duty_q reaches tgt_q at a wrap; pulse ramp_done.
  - RUN/RAMP→STOP when en=0.
  - STOP→IDLE at the next wrap.
- **Handshake:**
  - tgt_ready = 1 in IDLE, RUN and RAMP; 0 in STOP and during rst.
  - A handshake in RAMP overwrites tgt_q/step_q; the ramp continues from the current duty_q.
  - A handshake in IDLE only stores tgt_q/step_q.
- **Ramp arithmetic (at wrap only):**
  - If duty_q<tgt_q: duty_q = min(duty_q+step, tgt_q).
  - If duty_q>tgt_q: duty_q = max(duty_q−step, tgt_q).
  - Compute in WIDTH+1 bits, zero-extending step. No overshoot and no wrap-around.
- **Saturation:** duty > period_q is legal and yields 100% at the comparator. It is not clamped.
- **Counter:**
  - cnt increments while in RUN/RAMP/STOP.
  - When cnt==period_q, cnt→0 and period_q←period (the wrap).
  - period=0 gives a 1-clock PWM cycle; the block must still function.
- **Simultaneous events:**
  - Handshake on a wrap cycle: the new target takes effect from the following wrap.
  - en falling on a wrap cycle: the next period is still run in STOP, then IDLE.
  - en re-asserted during STOP: ignored until IDLE is reached.

## Timing
- All outputs are registered except tgt_ready, which is decoded from state and rst.
- **Reset values:** state=IDLE, counter_value=0, duty=0, pwm_en=0, period_end=0, ramp_done=0, busy=0; tgt_q=0, step_q=0.
- **rst mid-period:** takes effect on the next edge and abandons the period. A handshake in the same cycle as rst is dropped.
- **Start latency:** en sampled high at edge N gives pwm_en=1 and counter_value=0 after edge N+1.
- **Duty changes:** visible on the clock after period_end, coincident with counter_value=0.
- **Stop:** pwm_en drops in the same cycle counter_value returns to 0 after the final period_end.

## Structure
- The shared package `pwm_pkg` holds:
  - the state enum (IDLE, RUN, RAMP, STOP);
  - localparams for default WIDTH/STEP_W;
  - the saturating step function.
- One sub-module is natural: `pwm_period_counter` (cnt, period_q latch, wrap/period_end generation).
- The FSM and duty logic stay in the top.
- The comparator is instantiated by the parent, not inside this block.

## Test plan
- **Reset/idle:** rst=1 for 3 clocks, en=0 → all outputs 0, tgt_ready=1 after release.
- **Jump update:**
  - Stimulus: period=9, en=1, target 4 with step 0, accepted mid-period.
  - Required: duty changes 0→4 only on the clock after period_end; 10-clock cycles.
- **Ramp:**
  - Stimulus: period=99, target 50, step 20 from duty 0.
  - Required: duty sequence 20, 40, 50 across three wraps; ramp_done pulses once at 50. Then target 5, step 20 → 30, 10, 5.
- **Retarget mid-ramp:** ramping toward 80 with step 10 at duty 30, handshake target 0 with step 15 → 15, 0; no overshoot.
- **Graceful stop:** en dropped at cnt=3 with period=9 → counter continues to 9; period_end; then pwm_en=0 and state IDLE. An en pulse during STOP is ignored.
- **Edges:**
  - period=0 → period_end every clock.
  - duty=65535 with period=100 → duty held, no clamp.
  - rst asserted mid-ramp → all outputs return to 0 after one edge.
